seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment display driver for the on-board demo, replacing ad-hoc scan logic in board top levels.
- Scans DIGITS common-anode digits from an internal prescaler, with no separate scan clock.
- Shows a live word such as the PC.
- A pulsed event such as a memory write captures an alternate word and displays it for a programmable number of frames, then reverts to the live word.
- Adds per-digit decimal points and a blank mask.

---
 rtl/segdisp_pkg.sv | 23 ++
 rtl/seg_scan_prescaler.sv | 39 +++
 rtl/seg_scan_display.sv | 114 +++++++++++
 tb/tb_seg_scan_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/segdisp_pkg.sv
// Shared constants and helpers for the seven-segment scan display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package segdisp_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot prescaler for multiplexed scanners: emits tick once per REFRESH_DIV
// cycles, steps a digit index and flags the wrap to digit 0 as frame_start.
module seg_scan_prescaler
  import segdisp_pkg::*;
#(
  parameter int REFRESH_DIV = 32768,
  parameter int DIGITS      = 8,
  localparam int CW         = cnt_width(REFRESH_DIV),
  localparam int IW         = cnt_width(DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic          frame_start,
  output logic [IW-1:0] idx_next
);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0] count;
  logic [IW-1:0] idx;

  assign tick        = (count == CNT_LAST);
  assign frame_start = tick && (idx == IDX_LAST);
  assign idx_next    = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Index rests on the last digit so the first tick lands on digit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      idx   <= IDX_LAST;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) idx <= idx_next;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver with event-word hold, dp and blank masks.
// Optional leading-zero suppression is compiled in with SEGDISP_LZS_EN.
module seg_scan_display
  import segdisp_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 32768,
  parameter int HOLD_FRAMES    = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int W             = 4 * DIGITS,
  localparam int IW            = cnt_width(DIGITS),
  localparam int HW            = cnt_width(HOLD_FRAMES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W-1:0]      live_data,
  input  logic              evt_valid,
  input  logic [W-1:0]      evt_data,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              hold_active
);

  // Idle levels; XOR with an active-high value yields the pin level.
  localparam logic              POL_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{POL_LOW}};
  localparam logic [6:0]        SEG_INV = POL_LOW ? 7'b0000000 : 7'b1111111;
  localparam logic [6:0]        SEG_IDL = SEG_OFF ^ SEG_INV;

  logic          tick;
  logic          frame_start;
  logic [IW-1:0] idx_next;

  seg_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIGITS      (DIGITS)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .frame_start (frame_start),
    .idx_next    (idx_next)
  );

  logic [W-1:0]      evt_word;
  logic [W-1:0]      snapshot;
  logic [W-1:0]      snap_next;
  logic [HW-1:0]     hold_cnt;
  logic              hold_on;
  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        nib;
  logic              dark;
  logic [DIGITS-1:0] an_on;
  logic              dp_on;

  assign hold_on   = (hold_cnt != '0);
  assign snap_next = frame_start ? (hold_on ? evt_word : live_data) : snapshot;

`ifdef SEGDISP_LZS_EN
  // Digits above the highest nonzero nibble go dark; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    lz_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen_nz    = seen_nz | (snap_next[4*i +: 4] != 4'h0);
      lz_mask[i] = ~seen_nz;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    nib   = snap_next[{idx_next, 2'b00} +: 4];
    dark  = blank_mask[idx_next] | lz_mask[idx_next];
    an_on = dark ? '0 : (DIGITS'(1) << idx_next);
    dp_on = dp_mask[idx_next] & ~blank_mask[idx_next];
  end

  // evt_valid is a one-cycle strobe with no ready: every asserted cycle
  // captures evt_data and restarts the hold, overriding a pending decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_word    <= '0;
      snapshot    <= '0;
      hold_cnt    <= '0;
      hold_active <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_IDL;
      dp          <= POL_LOW;
    end else begin
      if (evt_valid) begin
        evt_word <= evt_data;
        hold_cnt <= HW'(HOLD_FRAMES);
      end else if (frame_start && hold_on) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (frame_start) begin
        snapshot    <= snap_next;
        hold_active <= hold_on;
      end
      if (tick) begin
        an  <= AN_OFF ^ an_on;
        seg <= hex_to_seg(nib) ^ SEG_INV;
        dp  <= POL_LOW ^ dp_on;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: DIGITS=8, REFRESH_DIV=4, HOLD_FRAMES=2.
// Expected LZS behaviour follows SEGDISP_LZS_EN when defined.
module tb_seg_scan_display;

  logic        clk;
  logic        reset;
  logic [31:0] live_data;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        hold_active;

  int n_pass;
  int n_total;

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [31:0] W0 = 32'h1234ABCD;
  localparam logic [31:0] E1 = 32'hEE500007;
  localparam logic [31:0] E2 = 32'h00000009;
`ifdef SEGDISP_LZS_EN
  localparam logic [7:0] LZ42 = 8'hFC;
`else
  localparam logic [7:0] LZ42 = 8'h00;
`endif

  seg_scan_display #(
    .DIGITS         (8),
    .REFRESH_DIV    (4),
    .HOLD_FRAMES    (2),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .live_data   (live_data),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .hold_active (hold_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one slot (4 clocks); optionally strobe an event on its first clock.
  task automatic next_slot(input bit pulse, input logic [31:0] d);
    if (pulse) begin
      evt_valid = 1'b1;
      evt_data  = d;
    end
    @(posedge clk);
    #1 evt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input int i, input logic [31:0] word, input logic hold,
                            input logic [7:0] bm, input logic [7:0] dm, input logic [7:0] lz);
    logic [7:0] an_e;
    logic [3:0] nb;
    logic       dp_e;
    an_e = (bm[i] | lz[i]) ? 8'hFF : ~(8'h01 << i);
    nb   = word[4*i +: 4];
    dp_e = ~(dm[i] & ~bm[i]);
    check($sformatf("an s%0d", i), {24'h0, an}, {24'h0, an_e});
    check($sformatf("seg s%0d", i), {25'h0, seg}, {25'h0, seg_ref[nb]});
    check($sformatf("dp s%0d", i), {31'h0, dp}, {31'h0, dp_e});
    check($sformatf("hold s%0d", i), {31'h0, hold_active}, {31'h0, hold});
  endtask

  task automatic slots(input int from, input int to, input logic [31:0] word, input logic hold,
                       input logic [7:0] bm, input logic [7:0] dm, input logic [7:0] lz,
                       input int pulse_at, input logic [31:0] pd);
    for (int i = from; i <= to; i++) begin
      next_slot(i == pulse_at, pd);
      check_slot(i, word, hold, bm, dm, lz);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " an"}, {24'h0, an}, 32'hFF);
    check({tag, " seg"}, {25'h0, seg}, 32'h7F);
    check({tag, " dp"}, {31'h0, dp}, 32'h1);
    check({tag, " hold"}, {31'h0, hold_active}, 32'h0);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b0;
    live_data  = W0;
    evt_valid  = 1'b0;
    evt_data   = '0;
    dp_mask    = '0;
    blank_mask = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;

    // first tick exactly 4 clocks after release, showing digit 0
    repeat (3) @(posedge clk);
    #1 check("pre_first_tick an", {24'h0, an}, 32'hFF);
    @(posedge clk);
    #1 check_slot(0, W0, 1'b0, 8'h00, 8'h00, 8'h00);
    slots(1, 7, W0, 1'b0, 8'h00, 8'h00, 8'h00, -1, '0);

    // frame 2: slot cadence, then an event strobe mid-frame
    repeat (3) @(posedge clk);
    #1 check("slot7_stable an", {24'h0, an}, 32'h7F);
    @(posedge clk);
    #1 check_slot(0, W0, 1'b0, 8'h00, 8'h00, 8'h00);
    slots(1, 7, W0, 1'b0, 8'h00, 8'h00, 8'h00, 4, E1);

    // event word held for exactly two frames, then live returns
    slots(0, 7, E1, 1'b1, 8'h00, 8'h00, 8'h00, -1, '0);
    slots(0, 7, E1, 1'b1, 8'h00, 8'h00, 8'h00, -1, '0);
    slots(0, 7, W0, 1'b0, 8'h00, 8'h00, 8'h00, 2, E1);

    // recapture during hold restarts the two-frame count
    slots(0, 7, E1, 1'b1, 8'h00, 8'h00, 8'h00, 3, E2);
    slots(0, 7, E2, 1'b1, 8'h00, 8'h00, 8'h00, -1, '0);
    slots(0, 7, E2, 1'b1, 8'h00, 8'h00, 8'h00, -1, '0);
    slots(0, 7, W0, 1'b0, 8'h00, 8'h00, 8'h00, -1, '0);

    // live change mid-frame must not tear the current frame
    live_data = 32'h0;
    slots(0, 3, 32'h0, 1'b0, 8'h00, 8'h00, 8'h00, -1, '0);
    live_data = 32'hFFFFFFFF;
    slots(4, 7, 32'h0, 1'b0, 8'h00, 8'h00, 8'h00, -1, '0);
    slots(0, 7, 32'hFFFFFFFF, 1'b0, 8'h00, 8'h00, 8'h00, -1, '0);

    // blank and decimal-point masks
    blank_mask = 8'h80;
    dp_mask    = 8'h01;
    slots(0, 7, 32'hFFFFFFFF, 1'b0, 8'h80, 8'h01, 8'h00, -1, '0);

    // asynchronous reset mid-slot
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_reset_wait an", {24'h0, an}, 32'hFF);
    @(posedge clk);
    #1 check_slot(0, 32'hFFFFFFFF, 1'b0, 8'h80, 8'h01, 8'h00);
    slots(1, 7, 32'hFFFFFFFF, 1'b0, 8'h80, 8'h01, 8'h00, -1, '0);

    // leading-zero suppression (dark above digit 1 only when compiled in)
    live_data  = 32'h00000042;
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    slots(0, 7, 32'h00000042, 1'b0, 8'h00, 8'h00, LZ42, -1, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
